// File: rtl/drac_pkg.sv
// Shared widths, parameters and lane payload types for the multi-lane rename table.
package drac_pkg;

    localparam int unsigned RENAME_WIDTH    = 2;
    localparam int unsigned COMMIT_WIDTH    = 2;
    localparam int unsigned NUM_WB          = 2;
    localparam int unsigned NUM_CHECKPOINTS = 4;
    localparam int unsigned NUM_ARCH_REGS   = 32;
    localparam int unsigned NUM_PHYS_REGS   = 64;

    localparam int unsigned REG_W   = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PHREG_W = $clog2(NUM_PHYS_REGS);
    localparam int unsigned CKPT_W  = $clog2(NUM_CHECKPOINTS);
    localparam int unsigned COUNT_W = CKPT_W + 1;

    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [PHREG_W-1:0] phreg_t;
    typedef logic [CKPT_W-1:0]  checkpoint_ptr;
    typedef logic [COUNT_W-1:0] ckpt_cnt_t;

    // One decoded lane as seen by the rename stage
    typedef struct packed {
        logic   valid;
        logic   use_rs1;
        logic   use_rs2;
        logic   write_dst;
        reg_t   src1;
        reg_t   src2;
        reg_t   old_dst;
        phreg_t new_dst;
    } lane_req_t;

    // Physical mappings and readiness for one lane
    typedef struct packed {
        phreg_t src1;
        phreg_t src2;
        phreg_t old_dst;
        logic   rdy1;
        logic   rdy2;
    } lane_map_t;

endpackage

// File: rtl/rename_bypass_net.sv
// Intra-group dependency override and write-back ready bypass for every rename lane.
module rename_bypass_net
    import drac_pkg::*;
(
    input  lane_req_t [RENAME_WIDTH-1:0] req_i,
    input  lane_map_t [RENAME_WIDTH-1:0] tbl_i,
    input  logic      [NUM_WB-1:0]       wb_valid_i,
    input  reg_t      [NUM_WB-1:0]       wb_vaddr_i,
    input  phreg_t    [NUM_WB-1:0]       wb_paddr_i,
    output lane_map_t [RENAME_WIDTH-1:0] map_c
);

    // An older lane in this group renames areg; the youngest such lane supplies the mapping
    function automatic logic older_hit(input int unsigned k, input reg_t areg);
        logic hit;
        hit = 1'b0;
        for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
            if (j < k && req_i[j].valid && req_i[j].write_dst &&
                req_i[j].old_dst != '0 && req_i[j].old_dst == areg) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic phreg_t resolve_phys(input int unsigned k, input reg_t areg,
                                            input phreg_t tbl_p);
        phreg_t p;
        p = tbl_p;
        for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
            if (j < k && req_i[j].valid && req_i[j].write_dst &&
                req_i[j].old_dst != '0 && req_i[j].old_dst == areg) begin
                p = req_i[j].new_dst;
            end
        end
        if (areg == '0) begin
            p = '0;
        end
        return p;
    endfunction

    function automatic logic resolve_rdy(input int unsigned k, input reg_t areg,
                                         input phreg_t tbl_p, input logic tbl_rdy,
                                         input logic use_src);
        logic r;
        r = tbl_rdy | ~use_src;
        for (int unsigned w = 0; w < NUM_WB; w++) begin
            if (wb_valid_i[w] && wb_vaddr_i[w] == areg && wb_paddr_i[w] == tbl_p) begin
                r = 1'b1;
            end
        end
        if (older_hit(k, areg)) begin
            r = ~use_src;
        end
        if (areg == '0) begin
            r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        map_c = '0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            map_c[k].src1    = resolve_phys(k, req_i[k].src1, tbl_i[k].src1);
            map_c[k].src2    = resolve_phys(k, req_i[k].src2, tbl_i[k].src2);
            map_c[k].old_dst = resolve_phys(k, req_i[k].old_dst, tbl_i[k].old_dst);
            map_c[k].rdy1    = resolve_rdy(k, req_i[k].src1, tbl_i[k].src1, tbl_i[k].rdy1,
                                           req_i[k].use_rs1);
            map_c[k].rdy2    = resolve_rdy(k, req_i[k].src2, tbl_i[k].src2, tbl_i[k].rdy2,
                                           req_i[k].use_rs2);
        end
    end

endmodule

// File: rtl/rename_table_multi.sv
// Multi-lane register alias table with checkpoint copies, wakeup tracking and a commit table.
module rename_table_multi
    import drac_pkg::*;
(
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [RENAME_WIDTH-1:0]                   valid_i,
    input  logic [RENAME_WIDTH-1:0][REG_W-1:0]        src1_i,
    input  logic [RENAME_WIDTH-1:0][REG_W-1:0]        src2_i,
    input  logic [RENAME_WIDTH-1:0]                   use_rs1_i,
    input  logic [RENAME_WIDTH-1:0]                   use_rs2_i,
    input  logic [RENAME_WIDTH-1:0][REG_W-1:0]        old_dst_i,
    input  logic [RENAME_WIDTH-1:0]                   write_dst_i,
    input  logic [RENAME_WIDTH-1:0][PHREG_W-1:0]      new_dst_i,
    input  logic [NUM_WB-1:0]                         wb_valid_i,
    input  logic [NUM_WB-1:0][REG_W-1:0]              wb_vaddr_i,
    input  logic [NUM_WB-1:0][PHREG_W-1:0]            wb_paddr_i,
    input  logic [COMMIT_WIDTH-1:0]                   commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][REG_W-1:0]        commit_old_dst_i,
    input  logic [COMMIT_WIDTH-1:0][PHREG_W-1:0]      commit_new_dst_i,
    input  logic                                      recover_commit_i,
    input  logic                                      do_checkpoint_i,
    input  logic                                      do_recover_i,
    input  logic [CKPT_W-1:0]                         recover_ckpt_i,
    input  logic                                      delete_checkpoint_i,
    output logic [RENAME_WIDTH-1:0][PHREG_W-1:0]      src1_o,
    output logic [RENAME_WIDTH-1:0][PHREG_W-1:0]      src2_o,
    output logic [RENAME_WIDTH-1:0][PHREG_W-1:0]      old_dst_o,
    output logic [RENAME_WIDTH-1:0]                   rdy1_o,
    output logic [RENAME_WIDTH-1:0]                   rdy2_o,
    output logic [CKPT_W-1:0]                         checkpoint_o,
    output logic                                      out_of_checkpoints_o
);

    phreg_t                    map_q    [NUM_CHECKPOINTS][NUM_ARCH_REGS];
    phreg_t                    map_d    [NUM_CHECKPOINTS][NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0]  rdy_q    [NUM_CHECKPOINTS];
    logic [NUM_ARCH_REGS-1:0]  rdy_d    [NUM_CHECKPOINTS];
    phreg_t                    commit_q [NUM_ARCH_REGS];
    phreg_t                    commit_d [NUM_ARCH_REGS];

    checkpoint_ptr head_q, head_d, tail_q, tail_d, tail_inc, head_inc;
    ckpt_cnt_t     count_q, count_d;
    logic          rename_en, ckpt_en;

    lane_req_t [RENAME_WIDTH-1:0] req;
    lane_map_t [RENAME_WIDTH-1:0] tbl;
    lane_map_t [RENAME_WIDTH-1:0] byp_c;

    assign out_of_checkpoints_o = (count_q == COUNT_W'(NUM_CHECKPOINTS - 1));
    assign rename_en = ~recover_commit_i & ~do_recover_i;
    assign ckpt_en   = rename_en & do_checkpoint_i & ~out_of_checkpoints_o;
    assign tail_inc  = tail_q + CKPT_W'(delete_checkpoint_i);
    assign head_inc  = head_q + CKPT_W'(1);

    // Pack lane requests and read the head copy for each lane
    always_comb begin
        req = '0;
        tbl = '0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            req[k].valid     = valid_i[k];
            req[k].use_rs1   = use_rs1_i[k];
            req[k].use_rs2   = use_rs2_i[k];
            req[k].write_dst = write_dst_i[k];
            req[k].src1      = src1_i[k];
            req[k].src2      = src2_i[k];
            req[k].old_dst   = old_dst_i[k];
            req[k].new_dst   = new_dst_i[k];
            tbl[k].src1      = map_q[head_q][src1_i[k]];
            tbl[k].src2      = map_q[head_q][src2_i[k]];
            tbl[k].old_dst   = map_q[head_q][old_dst_i[k]];
            tbl[k].rdy1      = rdy_q[head_q][src1_i[k]];
            tbl[k].rdy2      = rdy_q[head_q][src2_i[k]];
        end
    end

    rename_bypass_net u_bypass (
        .req_i      (req),
        .tbl_i      (tbl),
        .wb_valid_i (wb_valid_i),
        .wb_vaddr_i (wb_vaddr_i),
        .wb_paddr_i (wb_paddr_i),
        .map_c      (byp_c)
    );

    // Table, commit table and checkpoint pointer next state
    always_comb begin
        map_d    = map_q;
        rdy_d    = rdy_q;
        commit_d = commit_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (recover_commit_i) begin
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                map_d[0][r] = commit_q[r];
            end
            rdy_d[0] = '1;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHECKPOINTS; c++) begin
                for (int unsigned w = 0; w < NUM_WB; w++) begin
                    if (wb_valid_i[w] && map_q[c][wb_vaddr_i[w]] == wb_paddr_i[w]) begin
                        rdy_d[c][wb_vaddr_i[w]] = 1'b1;
                    end
                end
            end
            for (int unsigned p = 0; p < COMMIT_WIDTH; p++) begin
                if (commit_valid_i[p] && commit_old_dst_i[p] != '0) begin
                    commit_d[commit_old_dst_i[p]] = commit_new_dst_i[p];
                end
            end
            tail_d = tail_inc;
            if (do_recover_i) begin
                head_d  = recover_ckpt_i;
                count_d = COUNT_W'(CKPT_W'(recover_ckpt_i - tail_inc));
            end else begin
                // Later lanes overwrite earlier ones and override the wakeup
                for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
                    if (valid_i[k] && write_dst_i[k] && old_dst_i[k] != '0) begin
                        map_d[head_q][old_dst_i[k]] = new_dst_i[k];
                        rdy_d[head_q][old_dst_i[k]] = 1'b0;
                    end
                end
                if (ckpt_en) begin
                    map_d[head_inc] = map_d[head_q];
                    rdy_d[head_inc] = rdy_d[head_q];
                    head_d          = head_inc;
                end
                count_d = count_q + COUNT_W'(ckpt_en) - COUNT_W'(delete_checkpoint_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NUM_CHECKPOINTS; c++) begin
                for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                    map_q[c][r] <= PHREG_W'(r);
                end
                rdy_q[c] <= '1;
            end
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                commit_q[r] <= PHREG_W'(r);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_q    <= map_d;
            rdy_q    <= rdy_d;
            commit_q <= commit_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Registered rename results; held during branch recovery
    always_ff @(posedge clk_i) begin
        if (rst_i || recover_commit_i) begin
            src1_o       <= '0;
            src2_o       <= '0;
            old_dst_o    <= '0;
            rdy1_o       <= '0;
            rdy2_o       <= '0;
            checkpoint_o <= '0;
        end else if (!do_recover_i) begin
            for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
                src1_o[k]    <= byp_c[k].src1;
                src2_o[k]    <= byp_c[k].src2;
                old_dst_o[k] <= byp_c[k].old_dst;
                rdy1_o[k]    <= byp_c[k].rdy1;
                rdy2_o[k]    <= byp_c[k].rdy2;
            end
            checkpoint_o <= head_q;
        end
    end

    a_no_delete_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(delete_checkpoint_i && count_q == '0));

endmodule

// File: tb/tb_rename_table_multi.sv
// Scoreboard bench for rename_table_multi: directed groups push expectations, a negedge monitor checks them.
module tb_rename_table_multi;
    import drac_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [RENAME_WIDTH-1:0]              valid_i, use_rs1_i, use_rs2_i, write_dst_i;
    logic [RENAME_WIDTH-1:0][REG_W-1:0]   src1_i, src2_i, old_dst_i;
    logic [RENAME_WIDTH-1:0][PHREG_W-1:0] new_dst_i;
    logic [NUM_WB-1:0]                    wb_valid_i;
    logic [NUM_WB-1:0][REG_W-1:0]         wb_vaddr_i;
    logic [NUM_WB-1:0][PHREG_W-1:0]       wb_paddr_i;
    logic [COMMIT_WIDTH-1:0]              commit_valid_i;
    logic [COMMIT_WIDTH-1:0][REG_W-1:0]   commit_old_dst_i;
    logic [COMMIT_WIDTH-1:0][PHREG_W-1:0] commit_new_dst_i;
    logic recover_commit_i, do_checkpoint_i, do_recover_i, delete_checkpoint_i;
    logic [CKPT_W-1:0] recover_ckpt_i;
    logic [RENAME_WIDTH-1:0][PHREG_W-1:0] src1_o, src2_o, old_dst_o;
    logic [RENAME_WIDTH-1:0]              rdy1_o, rdy2_o;
    logic [CKPT_W-1:0]                    checkpoint_o;
    logic                                 out_of_checkpoints_o;

    rename_table_multi dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .src1_i(src1_i), .src2_i(src2_i), .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
        .old_dst_i(old_dst_i), .write_dst_i(write_dst_i), .new_dst_i(new_dst_i),
        .wb_valid_i(wb_valid_i), .wb_vaddr_i(wb_vaddr_i), .wb_paddr_i(wb_paddr_i),
        .commit_valid_i(commit_valid_i), .commit_old_dst_i(commit_old_dst_i),
        .commit_new_dst_i(commit_new_dst_i), .recover_commit_i(recover_commit_i),
        .do_checkpoint_i(do_checkpoint_i), .do_recover_i(do_recover_i),
        .recover_ckpt_i(recover_ckpt_i), .delete_checkpoint_i(delete_checkpoint_i),
        .src1_o(src1_o), .src2_o(src2_o), .old_dst_o(old_dst_o),
        .rdy1_o(rdy1_o), .rdy2_o(rdy2_o), .checkpoint_o(checkpoint_o),
        .out_of_checkpoints_o(out_of_checkpoints_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string                   name;
        logic [1:0][PHREG_W-1:0] s1, s2, od;
        logic [1:0]              r1, r2, m1, m2, mo;
        logic [CKPT_W-1:0]       ck;
        logic                    ooc, mck;
    } exp_t;

    exp_t cur;
    exp_t sb_q[$];
    logic exp_flag = 1'b0;
    logic obs = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk_i) obs <= exp_flag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: one expectation per observed cycle
    always @(negedge clk_i) begin
        if (obs) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    if (e.m1[k]) begin
                        chk($sformatf("%s.l%0d.src1", e.name, k), 32'(src1_o[k]), 32'(e.s1[k]));
                        chk($sformatf("%s.l%0d.rdy1", e.name, k), 32'(rdy1_o[k]), 32'(e.r1[k]));
                    end
                    if (e.m2[k]) begin
                        chk($sformatf("%s.l%0d.src2", e.name, k), 32'(src2_o[k]), 32'(e.s2[k]));
                        chk($sformatf("%s.l%0d.rdy2", e.name, k), 32'(rdy2_o[k]), 32'(e.r2[k]));
                    end
                    if (e.mo[k])
                        chk($sformatf("%s.l%0d.old_dst", e.name, k), 32'(old_dst_o[k]), 32'(e.od[k]));
                end
                if (e.mck) begin
                    chk($sformatf("%s.ckpt", e.name), 32'(checkpoint_o), 32'(e.ck));
                    chk($sformatf("%s.ooc", e.name), 32'(out_of_checkpoints_o), 32'(e.ooc));
                end
            end
        end
    end

    task automatic idle();
        rst_i = 1'b0; valid_i = '0; use_rs1_i = '0; use_rs2_i = '0; write_dst_i = '0;
        src1_i = '0; src2_i = '0; old_dst_i = '0; new_dst_i = '0;
        wb_valid_i = '0; wb_vaddr_i = '0; wb_paddr_i = '0;
        commit_valid_i = '0; commit_old_dst_i = '0; commit_new_dst_i = '0;
        recover_commit_i = 1'b0; do_checkpoint_i = 1'b0; do_recover_i = 1'b0;
        recover_ckpt_i = '0; delete_checkpoint_i = 1'b0;
        cur.m1 = '0; cur.m2 = '0; cur.mo = '0; cur.mck = 1'b0;
        cur.s1 = '0; cur.s2 = '0; cur.od = '0; cur.r1 = '0; cur.r2 = '0;
        cur.ck = '0; cur.ooc = 1'b0;
    endtask

    task automatic ln(input int k, input int s1, input logic u1, input int s2 = 0,
                      input logic u2 = 1'b0, input int d = 0, input logic wr = 1'b0,
                      input int np = 0);
        valid_i[k] = 1'b1; src1_i[k] = REG_W'(s1); use_rs1_i[k] = u1;
        src2_i[k] = REG_W'(s2); use_rs2_i[k] = u2; old_dst_i[k] = REG_W'(d);
        write_dst_i[k] = wr; new_dst_i[k] = PHREG_W'(np);
    endtask

    task automatic wb(input int w, input int v, input int p);
        wb_valid_i[w] = 1'b1; wb_vaddr_i[w] = REG_W'(v); wb_paddr_i[w] = PHREG_W'(p);
    endtask

    task automatic cm(input int w, input int v, input int p);
        commit_valid_i[w] = 1'b1; commit_old_dst_i[w] = REG_W'(v); commit_new_dst_i[w] = PHREG_W'(p);
    endtask

    task automatic ex1(input int k, input int p, input logic r);
        cur.m1[k] = 1'b1; cur.s1[k] = PHREG_W'(p); cur.r1[k] = r;
    endtask
    task automatic ex2(input int k, input int p, input logic r);
        cur.m2[k] = 1'b1; cur.s2[k] = PHREG_W'(p); cur.r2[k] = r;
    endtask
    task automatic exo(input int k, input int p);
        cur.mo[k] = 1'b1; cur.od[k] = PHREG_W'(p);
    endtask
    task automatic exc(input int ck, input logic ooc);
        cur.mck = 1'b1; cur.ck = CKPT_W'(ck); cur.ooc = ooc;
    endtask
    task automatic ex_zero();
        cur.m1 = '1; cur.m2 = '1; cur.mo = '1; cur.mck = 1'b1;
    endtask

    task automatic step(input string nm);
        cur.name = nm;
        sb_q.push_back(cur);
        exp_flag = 1'b1;
        @(negedge clk_i);
        exp_flag = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1; ex_zero(); step("reset");

        ln(0, 5, 1, 0, 1); ln(1, 0, 1, 0, 0, 0, 1, 33);
        ex1(0, 5, 1); ex2(0, 0, 1); exo(0, 0); ex1(1, 0, 1); exo(1, 0); exc(0, 0); step("x5_x0");
        ln(0, 3, 1, 0, 0, 3, 1, 40); ln(1, 3, 1, 0, 0, 3, 1, 41);
        ex1(0, 3, 1); exo(0, 3); ex1(1, 40, 0); exo(1, 40); step("bypass");
        ln(0, 3, 1); ln(1, 0, 0, 3, 0);
        ex1(0, 41, 0); ex2(1, 41, 1); step("youngest_wins");
        ln(0, 0, 0, 0, 0, 9, 1, 50); exo(0, 9); step("wr_x9");
        ln(0, 9, 1); wb(0, 9, 50); ex1(0, 50, 1); step("wb_bypass");
        ln(0, 9, 1, 0, 0, 9, 1, 52); wb(1, 9, 50); ex1(0, 50, 1); exo(0, 50); step("wb_vs_rename");
        ln(0, 9, 1); ex1(0, 52, 0); step("rename_wins");
        recover_commit_i = 1'b1; ln(0, 0, 0, 0, 0, 9, 1, 10); ex_zero(); step("rc_clear");
        ln(0, 9, 1, 3, 1); ex1(0, 9, 1); ex2(0, 3, 1); exc(0, 0); step("rc_restore");

        do_checkpoint_i = 1'b1; ln(0, 7, 1); ex1(0, 7, 1); exc(0, 0); step("ckpt0");
        ln(0, 7, 1, 0, 0, 7, 1, 50); ex1(0, 7, 1); exo(0, 7); exc(1, 0); step("spec_wr_x7");
        do_recover_i = 1'b1; recover_ckpt_i = 2'd1; ln(0, 5, 1);
        ex1(0, 7, 1); exc(1, 0); step("recover1_hold");
        ln(0, 7, 1); ex1(0, 50, 0); exc(1, 0); step("recover1_x7");
        do_recover_i = 1'b1; recover_ckpt_i = 2'd0; ex1(0, 50, 0); exc(1, 0); step("recover0_hold");
        ln(0, 7, 1); ex1(0, 7, 1); exc(0, 0); step("recover0_x7");

        do_checkpoint_i = 1'b1; ln(0, 0, 0, 0, 0, 12, 1, 45); exo(0, 12); exc(0, 0); step("full_c1");
        do_checkpoint_i = 1'b1; ln(0, 12, 1); ex1(0, 45, 0); exc(1, 0); step("full_c2");
        do_checkpoint_i = 1'b1; exc(2, 1); step("full_c3");
        do_checkpoint_i = 1'b1; wb(0, 12, 45); exc(3, 1); step("full_ignored");
        ln(0, 12, 1); ex1(0, 45, 1); exc(3, 1); step("full_head3");
        do_recover_i = 1'b1; recover_ckpt_i = 2'd1; ex1(0, 45, 1); exc(3, 0); step("rec_ck1_hold");
        ln(0, 12, 1); ex1(0, 45, 1); exc(1, 0); step("copy1_woken");
        delete_checkpoint_i = 1'b1; ln(0, 12, 1); ex1(0, 45, 1); exc(1, 0); step("delete");
        do_checkpoint_i = 1'b1; exc(1, 0); step("wrap_c1");
        do_checkpoint_i = 1'b1; exc(2, 0); step("wrap_c2");
        do_checkpoint_i = 1'b1; exc(3, 1); step("wrap_c3");
        ln(0, 12, 1); ex1(0, 45, 1); exc(0, 1); step("wrap_head0");

        cm(0, 4, 60); cm(1, 4, 61); ln(0, 4, 1); ex1(0, 4, 1); exc(0, 1); step("commit");
        recover_commit_i = 1'b1; ln(0, 0, 0, 0, 0, 4, 1, 20); ex_zero(); step("rc2_clear");
        ln(0, 4, 1); ln(1, 12, 1); ex1(0, 61, 1); ex1(1, 12, 1); exc(0, 0); step("rc2_restore");
        rst_i = 1'b1; ln(0, 0, 0, 0, 0, 4, 1, 22); ex_zero(); step("mid_reset");
        ln(0, 4, 1); ex1(0, 4, 1); exc(0, 0); step("post_reset");

        repeat (2) @(negedge clk_i);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
